// File: rtl/generador_nivel_comida.sv
// Food-level generator for the pet FSM: debounced feed button, 1 s prescaler,
// periodic level decay and feed requests gated by Activo_Comida.
module generador_nivel_comida #(
    parameter int unsigned TICK_DIV      = 50_000_000,
    parameter int unsigned DECAY_SEG     = 10,
    parameter int unsigned DEBOUNCE_CYC  = 500_000,
    parameter logic [1:0]  NIVEL_INICIAL = 2'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Boton_Raw,
    input  logic       Activo_Comida,
    output logic [1:0] Nivel_Comida,
    output logic       Boton_Comida,
    output logic       Pulso_Comer,
    output logic       Rechazo,
    output logic       Tick_1s
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (DECAY_SEG > 1) ? $clog2(DECAY_SEG) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [PW-1:0] PCNT_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DCNT_MAX = DW'(DECAY_SEG - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        Soltado,
        ConfirmaPres,
        Presionado,
        ConfirmaSolt
    } estado_t;

    logic          sync_q;
    logic          btn_s;
    estado_t       estado_q;
    logic [CW-1:0] cnt_q;
    logic          press_ev_q;
    logic          clr_lleno_q;
    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic [DW-1:0] dcnt_q;
    logic          puede_comer;
    logic          limpia;
    logic          expira;

    // Two-flop synchronizer; btn_s is the only consumer of Boton_Raw.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            sync_q <= Boton_Raw;
            btn_s  <= sync_q;
        end
    end

    // Debounce FSM; Boton_Comida is the registered image of the pressed states.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q     <= Soltado;
            cnt_q        <= '0;
            press_ev_q   <= 1'b0;
            Boton_Comida <= 1'b0;
        end else begin
            press_ev_q   <= 1'b0;
            Boton_Comida <= (estado_q == Presionado) || (estado_q == ConfirmaSolt);
            unique case (estado_q)
                Soltado: begin
                    if (btn_s) begin
                        estado_q <= ConfirmaPres;
                        cnt_q    <= '0;
                    end
                end
                ConfirmaPres: begin
                    if (!btn_s) begin
                        estado_q <= Soltado;
                    end else if (cnt_q == CNT_MAX) begin
                        estado_q   <= Presionado;
                        press_ev_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                Presionado: begin
                    if (!btn_s) begin
                        estado_q <= ConfirmaSolt;
                        cnt_q    <= '0;
                    end
                end
                ConfirmaSolt: begin
                    if (btn_s) begin
                        estado_q <= Presionado;
                    end else if (cnt_q == CNT_MAX) begin
                        estado_q <= Soltado;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: estado_q <= Soltado;
            endcase
        end
    end

    assign puede_comer = Activo_Comida && (Nivel_Comida != 2'd3);

    // Press decision lands on the same edge Boton_Comida rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            Pulso_Comer <= 1'b0;
            Rechazo     <= 1'b0;
            clr_lleno_q <= 1'b0;
        end else begin
            Pulso_Comer <= press_ev_q && puede_comer;
            Rechazo     <= press_ev_q && !puede_comer;
            clr_lleno_q <= press_ev_q && Activo_Comida && (Nivel_Comida == 2'd3);
        end
    end

    always_comb begin
        pcnt_d = pcnt_q + 1'b1;
        if (pcnt_q == PCNT_MAX) begin
            pcnt_d = '0;
        end
    end

    // Free-running prescaler; Tick_1s is registered from the next count.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q  <= '0;
            Tick_1s <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            Tick_1s <= (pcnt_d == PCNT_MAX);
        end
    end

    assign limpia = Pulso_Comer || clr_lleno_q;
    assign expira = Tick_1s && (dcnt_q == DCNT_MAX);

    // Feeding beats a coinciding decay expiry; level saturates at both ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            Nivel_Comida <= NIVEL_INICIAL;
            dcnt_q       <= '0;
        end else begin
            if (Pulso_Comer) begin
                if (Nivel_Comida != 2'd3) begin
                    Nivel_Comida <= Nivel_Comida + 2'd1;
                end
            end else if (!limpia && expira && (Nivel_Comida != 2'd0)) begin
                Nivel_Comida <= Nivel_Comida - 2'd1;
            end

            if (limpia || expira) begin
                dcnt_q <= '0;
            end else if (Tick_1s) begin
                dcnt_q <= dcnt_q + 1'b1;
            end
        end
    end

endmodule
